// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory controller.
//   - MemSize encodings (byte / half / word; 2'b11 is illegal)
//   - FSM state encoding
//   - access_illegal(): combinational legality check of a request
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // True only for an actual request (rd|wr) that must be rejected.
    function automatic logic access_illegal(
        input logic        rd,
        input logic        wr,
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [31:0] depth
    );
        logic bad;
        bad = rd & wr;
        if (size == SIZE_HALF) begin
            bad = bad | addr[0];
        end else if (size == SIZE_WORD) begin
            bad = bad | (addr[1:0] != 2'b00);
        end else if (size != SIZE_BYTE) begin
            bad = 1'b1;
        end
        if ({2'b00, addr[31:2]} >= depth) begin
            bad = 1'b1;
        end
        return (rd | wr) & bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory (little-endian, lane k = bits [8k+7:8k]).
// Ports:
//   size_i      access size (mem_pkg SIZE_*)
//   offset_i    Address[1:0]
//   unsigned_i  1 = zero-extend loads, 0 = sign-extend
//   wdata_i     store data, right-justified
//   rword_i     word currently stored at the addressed index
//   be_o        byte-write mask
//   wword_o     rword_i with the addressed lanes replaced by store data
//   rdata_o     extracted, right-justified and extended load data
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    logic [31:0] wlanes;
    logic [31:0] shifted;
    logic [4:0]  shamt;

    always_comb begin
        be_o    = 4'b0000;
        wlanes  = wdata_i;
        shamt   = 5'd0;
        rdata_o = 32'h0;
        wword_o = rword_i;

        case (size_i)
            SIZE_BYTE: begin
                be_o   = 4'b0001 << offset_i;
                wlanes = {4{wdata_i[7:0]}};
                shamt  = {offset_i, 3'b000};
            end
            SIZE_HALF: begin
                be_o   = offset_i[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_i[15:0]}};
                shamt  = {offset_i[1], 4'b0000};
            end
            SIZE_WORD: be_o = 4'b1111;
            default:   be_o = 4'b0000;
        endcase

        shifted = rword_i >> shamt;

        case (size_i)
            SIZE_BYTE: rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            SIZE_WORD: rdata_o = rword_i;
            default:   rdata_o = 32'h0;
        endcase

        for (int k = 0; k < 4; k++) begin
            if (be_o[k]) begin
                wword_o[8*k +: 8] = wlanes[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory for the pipelined MIPS core.
// Byte/half/word loads and stores, configurable access latency via MemStall,
// and detection of misaligned, out-of-range and conflicting accesses.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   MemRead, MemWrite      load / store request
//   MemSize, MemUnsigned   access size, zero- vs sign-extension of loads
//   Address, Writedata     byte address, store data
//   Readdata               load result, non-zero only in a read completion cycle
//   MemStall               access pending; core holds inputs stable
//   MemFault               one-cycle pulse on an illegal access
//   FaultAddr              address of the most recent faulting access
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    input  logic [31:0] Address,
    input  logic [31:0] Writedata,
    output logic [31:0] Readdata,
    output logic        MemStall,
    output logic        MemFault,
    output logic [31:0] FaultAddr
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0]  LAT   = 3'(LATENCY);
    localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] fault_addr_q;

    logic             req, illegal;
    logic             stall, fault, complete, we;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rword, wword, ld_data;
    logic [3:0]       be;

    assign req     = MemRead | MemWrite;
    assign illegal = access_illegal(MemRead, MemWrite, MemSize, Address, DEPTH);
    assign idx     = Address[IDX_W+1:2];
    assign rword   = mem[idx];

    mem_lane_align u_align (
        .size_i     (MemSize),
        .offset_i   (Address[1:0]),
        .unsigned_i (MemUnsigned),
        .wdata_i    (Writedata),
        .rword_i    (rword),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            fault_addr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (fault) begin
                fault_addr_q <= Address;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req && !illegal && (LAT != 3'd0)) begin
                    state_d = ST_BUSY;
                    cnt_d   = 3'd1;
                end
            end
            ST_BUSY: begin
                // Dropped request is a pipeline flush; otherwise finish at cnt == LAT.
                if (!req || (cnt_q == LAT)) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        stall    = 1'b0;
        fault    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (illegal) begin
                        fault = 1'b1;
                    end else if (LAT == 3'd0) begin
                        complete = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (req) begin
                    if (cnt_q == LAT) begin
                        complete = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Gate with rst_n so nothing leaks out (or commits) while reset is held.
    assign we        = complete & MemWrite & rst_n;
    assign MemStall  = stall & rst_n;
    assign MemFault  = fault & rst_n;
    assign Readdata  = (complete && MemRead && rst_n) ? ld_data : 32'h0;
    assign FaultAddr = fault_addr_q;

    // Array is intentionally not reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we && be[k]) begin
                mem[idx][8*k +: 8] <= wword[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: three instances (LATENCY 0, 3, 4) with independent request
// signals and shared clock/reset.
module tb_data_memory_ctrl;

    logic clk;
    logic rst_n;

    logic [2:0]       rd, wr, us, stall, fault;
    logic [2:0][1:0]  sz;
    logic [2:0][31:0] addr, wd, rdata, faddr;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(0)) dut_l0 (
        .clk(clk), .rst_n(rst_n), .MemRead(rd[0]), .MemWrite(wr[0]), .MemSize(sz[0]),
        .MemUnsigned(us[0]), .Address(addr[0]), .Writedata(wd[0]), .Readdata(rdata[0]),
        .MemStall(stall[0]), .MemFault(fault[0]), .FaultAddr(faddr[0])
    );

    data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .MemRead(rd[1]), .MemWrite(wr[1]), .MemSize(sz[1]),
        .MemUnsigned(us[1]), .Address(addr[1]), .Writedata(wd[1]), .Readdata(rdata[1]),
        .MemStall(stall[1]), .MemFault(fault[1]), .FaultAddr(faddr[1])
    );

    data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(4)) dut_l4 (
        .clk(clk), .rst_n(rst_n), .MemRead(rd[2]), .MemWrite(wr[2]), .MemSize(sz[2]),
        .MemUnsigned(us[2]), .Address(addr[2]), .Writedata(wd[2]), .Readdata(rdata[2]),
        .MemStall(stall[2]), .MemFault(fault[2]), .FaultAddr(faddr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic r, input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] a, input logic [31:0] d);
        rd[i] = r; wr[i] = w; sz[i] = s; us[i] = u; addr[i] = a; wd[i] = d;
    endtask

    task automatic idle(input int i);
        drive(i, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    // Issue one access, wait (bounded) through stalls, sample completion values
    // at the negedge, return just after the completion edge with inputs still set.
    task automatic access(input int i, input logic r, input logic w, input logic [1:0] s,
                          input logic u, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rv, output logic fl, output int ns);
        ns = 0;
        drive(i, r, w, s, u, a, d);
        @(negedge clk);
        while (stall[i] && ns < 16) begin
            chk("rdata_during_stall", rdata[i], 32'h0);
            ns++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        rv = rdata[i];
        fl = fault[i];
        @(posedge clk); #1;
    endtask

    logic [31:0] rv;
    logic        fl;
    int          ns;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) idle(i);
        #2;
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_stall", 32'(stall[1]), 32'h0);
        chk("rst_fault", 32'(fault[1]), 32'h0);
        chk("rst_faddr", faddr[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- LATENCY = 0 ----------------
        access(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rv, fl, ns);
        chk("l0_sw_stalls", 32'(ns), 0);
        chk("l0_sw_fault", 32'(fl), 0);
        access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, rv, fl, ns);
        chk("l0_lw", rv, 32'hDEADBEEF);
        chk("l0_lw_stalls", 32'(ns), 0);
        access(0, 0, 1, 2'b00, 0, 32'h11, 32'h0000005A, rv, fl, ns);
        access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, rv, fl, ns);
        chk("l0_after_sb", rv, 32'hDEAD5AEF);
        access(0, 1, 0, 2'b00, 0, 32'h13, 32'h0, rv, fl, ns);
        chk("l0_lb", rv, 32'hFFFFFFDE);
        access(0, 1, 0, 2'b00, 1, 32'h13, 32'h0, rv, fl, ns);
        chk("l0_lbu", rv, 32'h000000DE);
        access(0, 1, 0, 2'b01, 0, 32'h12, 32'h0, rv, fl, ns);
        chk("l0_lh", rv, 32'hFFFFDEAD);
        access(0, 1, 0, 2'b01, 1, 32'h10, 32'h0, rv, fl, ns);
        chk("l0_lhu", rv, 32'h00005AEF);
        access(0, 1, 0, 2'b01, 0, 32'h10, 32'h0, rv, fl, ns);
        chk("l0_lh_pos", rv, 32'h00005AEF);
        idle(0);
        @(negedge clk);
        chk("l0_idle_rdata", rdata[0], 32'h0);
        @(posedge clk); #1;

        // Faults
        access(0, 1, 0, 2'b10, 0, 32'h12, 32'h0, rv, fl, ns);
        chk("f_lw12_fault", 32'(fl), 1);
        chk("f_lw12_stalls", 32'(ns), 0);
        chk("f_lw12_rdata", rv, 32'h0);
        chk("f_lw12_faddr", faddr[0], 32'h12);
        idle(0);
        @(negedge clk);
        chk("f_pulse_end", 32'(fault[0]), 0);
        @(posedge clk); #1;
        access(0, 1, 0, 2'b01, 0, 32'h13, 32'h0, rv, fl, ns);
        chk("f_lh13_fault", 32'(fl), 1);
        chk("f_lh13_faddr", faddr[0], 32'h13);
        access(0, 0, 1, 2'b10, 0, 32'h400, 32'hFFFFFFFF, rv, fl, ns);
        chk("f_oor_fault", 32'(fl), 1);
        chk("f_oor_faddr", faddr[0], 32'h400);
        access(0, 1, 1, 2'b10, 0, 32'h10, 32'h0, rv, fl, ns);
        chk("f_rw_fault", 32'(fl), 1);
        chk("f_rw_stalls", 32'(ns), 0);
        chk("f_rw_faddr", faddr[0], 32'h10);
        access(0, 0, 1, 2'b11, 0, 32'h14, 32'hFFFFFFFF, rv, fl, ns);
        chk("f_size11_fault", 32'(fl), 1);
        access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, rv, fl, ns);
        chk("f_mem_unchanged", rv, 32'hDEAD5AEF);
        chk("f_legal_nofault", 32'(fl), 0);
        idle(0);

        // ---------------- LATENCY = 3 ----------------
        access(1, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rv, fl, ns);
        chk("l3_sw_stalls", 32'(ns), 3);
        access(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, rv, fl, ns);
        chk("l3_lw", rv, 32'hDEADBEEF);
        chk("l3_lw_stalls", 32'(ns), 3);
        // Back-to-back store: array must change only at the completion edge.
        drive(1, 0, 1, 2'b10, 0, 32'h10, 32'h01020304);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("l3_sw_stall", 32'(stall[1]), 1);
            @(posedge clk); #1;
            chk("l3_mem_held", dut_l3.mem[4], 32'hDEADBEEF);
        end
        @(negedge clk);
        chk("l3_sw_done", 32'(stall[1]), 0);
        @(posedge clk); #1;
        chk("l3_mem_new", dut_l3.mem[4], 32'h01020304);
        access(1, 1, 0, 2'b00, 1, 32'h12, 32'h0, rv, fl, ns);
        chk("l3_lbu", rv, 32'h00000002);
        chk("l3_lbu_stalls", 32'(ns), 3);
        access(1, 1, 0, 2'b10, 0, 32'h12, 32'h0, rv, fl, ns);
        chk("l3_f_fault", 32'(fl), 1);
        chk("l3_f_stalls", 32'(ns), 0);
        chk("l3_f_faddr", faddr[1], 32'h12);
        idle(1);

        // ---------------- LATENCY = 4, abort ----------------
        access(2, 0, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, rv, fl, ns);
        chk("l4_sw_stalls", 32'(ns), 4);
        drive(2, 0, 1, 2'b10, 0, 32'h20, 32'h00001234);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("l4_ab_stall", 32'(stall[2]), 1);
            @(posedge clk); #1;
        end
        idle(2);
        #1;
        chk("l4_ab_stall_drop", 32'(stall[2]), 0);
        @(posedge clk); #1;
        access(2, 1, 0, 2'b10, 0, 32'h20, 32'h0, rv, fl, ns);
        chk("l4_ab_old", rv, 32'hCAFEF00D);
        chk("l4_ab_idle_stalls", 32'(ns), 4);
        idle(2);

        // ---------------- Reset mid-BUSY (LATENCY = 3) ----------------
        drive(1, 0, 1, 2'b10, 0, 32'h10, 32'h55555555);
        @(negedge clk);
        chk("r_stall_pre", 32'(stall[1]), 1);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("r_stall", 32'(stall[1]), 0);
        chk("r_fault", 32'(fault[1]), 0);
        chk("r_rdata", rdata[1], 32'h0);
        chk("r_faddr", faddr[1], 32'h0);
        @(posedge clk); #1;
        idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, rv, fl, ns);
        chk("r_old_data", rv, 32'h01020304);
        chk("r_lw_stalls", 32'(ns), 3);
        idle(1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
